// File: rtl/des_subkey_gen_if.sv
// Subkey stream from the DES key schedule to the F-function key-mix stage.
// The master presents one 48-bit subkey and its round index per valid/ready handshake.
interface des_subkey_gen_if;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] subkey;
  logic [3:0]  round;

  modport master (output sk_valid, output subkey, output round, input sk_ready);
  modport slave  (input sk_valid, input subkey, input round, output sk_ready);
endinterface

// File: rtl/des_subkey_gen.sv
// Sequential DES key schedule: one C/D register pair and a step counter produce
// K1..K16 (or K16..K1 when decrypting), one subkey per handshake.
module des_subkey_gen (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   decrypt,
  input  logic [63:0]            key,
  output logic                   busy,
  output logic                   done,
  des_subkey_gen_if.master       sk
);

  // Tables use FIPS 1-based bit numbers; FIPS bit n of the key is key[64-n].
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t      state_reg, state_next;
  logic [27:0] c_reg, c_next;
  logic [27:0] d_reg, d_next;
  logic [3:0]  s_reg, s_next;
  logic        dec_reg, dec_next;
  logic        done_reg, done_next;

  logic [55:0] pc1_key;
  logic [55:0] cd;
  logic [47:0] pc2_out;
  logic        valid;
  logic        parity_unused;

  assign parity_unused = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8], key[0]};

  generate
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_key[55-gi] = key[64-PC1[gi]];
    end
  endgenerate

  assign cd = {c_reg, d_reg};

  generate
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2_out[47-gi] = cd[56-PC2[gi]];
    end
  endgenerate

  function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic two);
    logic [27:0] r;
    if (left && !two)      r = {x[26:0], x[27]};
    else if (left && two)  r = {x[25:0], x[27:26]};
    else if (!two)         r = {x[0], x[27:1]};
    else                   r = {x[1:0], x[27:2]};
    return r;
  endfunction

  // Schedule positions K1, K2, K9 and K16 shift by one, all others by two.
  function automatic logic one_shift(input logic [4:0] idx);
    return (idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16);
  endfunction

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    s_next     = s_reg;
    dec_next   = dec_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // Encrypt preloads the K1 shift; decrypt starts from C16,D16 = C0,D0.
          c_next     = decrypt ? pc1_key[55:28] : rot(pc1_key[55:28], 1'b1, 1'b0);
          d_next     = decrypt ? pc1_key[27:0]  : rot(pc1_key[27:0],  1'b1, 1'b0);
          s_next     = 4'd0;
          dec_next   = decrypt;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (sk.sk_ready) begin
          if (s_reg == 4'd15) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + 4'd1;
          end
          if (dec_reg) begin
            c_next = rot(c_reg, 1'b0, !one_shift(5'd16 - {1'b0, s_reg}));
            d_next = rot(d_reg, 1'b0, !one_shift(5'd16 - {1'b0, s_reg}));
          end else if (s_reg != 4'd15) begin
            c_next = rot(c_reg, 1'b1, !one_shift({1'b0, s_reg} + 5'd2));
            d_next = rot(d_reg, 1'b1, !one_shift({1'b0, s_reg} + 5'd2));
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      s_reg     <= '0;
      dec_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      s_reg     <= s_next;
      dec_reg   <= dec_next;
      done_reg  <= done_next;
    end
  end

  assign valid       = (state_reg == EMIT);
  assign sk.sk_valid = valid;
  assign sk.subkey   = valid ? pc2_out : '0;
  assign sk.round    = valid ? (dec_reg ? (4'd15 - s_reg) : s_reg) : 4'd0;
  assign busy        = valid;
  assign done        = done_reg;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Randomized scoreboard bench for des_subkey_gen: a table-driven DES key schedule
// model fills an expectation queue; a negedge monitor checks every handshake.
module tb_des_subkey_gen;

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS_T [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        busy;
  logic        done;

  des_subkey_gen_if sk_if ();

  des_subkey_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .decrypt (decrypt),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .sk      (sk_if)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          hs_count = 0;
  int          ready_mode = 0;
  int          stall_left = 0;
  bit          mon_en = 1'b0;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [47:0] ref_ks [0:15];
  bit          done_exp = 1'b0;
  bit          prev_stall = 1'b0;
  logic [47:0] prev_sk;
  logic [3:0]  prev_rnd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: subkey i is PC-2 of PC-1(key) with each half rotated left by the
  // cumulative shift count, using 1-based FIPS bit arrays.
  task automatic compute_ref(input logic [63:0] k);
    bit kb [1:64];
    bit cd0 [1:56];
    int tot;
    int p;
    for (int i = 1; i <= 64; i++) kb[i] = k[64-i];
    for (int i = 1; i <= 56; i++) cd0[i] = kb[PC1_T[i-1]];
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += SHIFTS_T[r];
      for (int j = 1; j <= 48; j++) begin
        p = PC2_T[j-1];
        if (p <= 28) ref_ks[r][48-j] = cd0[((p - 1 + tot) % 28) + 1];
        else         ref_ks[r][48-j] = cd0[29 + ((p - 29 + tot) % 28)];
      end
    end
  endtask

  task automatic push_sched(input logic [63:0] k, input logic d);
    exp_t e;
    compute_ref(k);
    for (int n = 0; n < 16; n++) begin
      e.rnd  = d ? 4'(15 - n) : 4'(n);
      e.sk   = ref_ks[e.rnd];
      e.last = (n == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] k, input logic d, input logic [63:0] model_key);
    start   = 1'b1;
    key     = k;
    decrypt = d;
    push_sched(model_key, d);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (ready_mode == 0) begin
      sk_if.sk_ready = 1'b1;
    end else if (stall_left > 0) begin
      sk_if.sk_ready = 1'b0;
      stall_left--;
    end else begin
      sk_if.sk_ready = 1'b1;
      stall_left = $urandom_range(0, 5);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("done_pulse", 64'(done), 64'(done_exp));
      done_exp = 1'b0;
      if (sk_if.sk_valid === 1'b1) begin
        if (prev_stall) begin
          check("stall_subkey_stable", 64'(sk_if.subkey), 64'(prev_sk));
          check("stall_round_stable", 64'(sk_if.round), 64'(prev_rnd));
        end
        if (sk_if.sk_ready === 1'b1) begin
          hs_count++;
          prev_stall = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_subkey: got %h expected none", sk_if.subkey);
          end else begin
            mon_e = exp_q.pop_front();
            $display("hs round %0d subkey %012h", sk_if.round, sk_if.subkey);
            check("subkey", 64'(sk_if.subkey), 64'(mon_e.sk));
            check("round", 64'(sk_if.round), 64'(mon_e.rnd));
            done_exp = mon_e.last;
          end
        end else begin
          prev_stall = 1'b1;
          prev_sk    = sk_if.subkey;
          prev_rnd   = sk_if.round;
        end
      end else begin
        check("idle_subkey_zero", 64'(sk_if.subkey), 64'd0);
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int base;
    logic [63:0] rk;
    logic rd;
    rst = 1'b1;
    start = 1'b0;
    decrypt = 1'b0;
    key = '0;
    sk_if.sk_ready = 1'b0;
    repeat (3) tick();
    check("reset_valid", 64'(sk_if.sk_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_subkey", 64'(sk_if.subkey), 64'd0);
    check("reset_round", 64'(sk_if.round), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    compute_ref(KEY0);
    check("model_k1", 64'(ref_ks[0]), 64'h1B02EFFC7072);
    check("model_k2", 64'(ref_ks[1]), 64'h79AED9DBC9E5);
    check("model_k16", 64'(ref_ks[15]), 64'hCB3D8B0E17F5);

    // Encrypt with full throughput, then decrypt started in the done cycle.
    ready_mode = 0;
    tick();
    issue(KEY0, 1'b0, KEY0);
    check("enc_first_valid", 64'(sk_if.sk_valid), 64'd1);
    check("enc_first_busy", 64'(busy), 64'd1);
    check("enc_first_subkey", 64'(sk_if.subkey), 64'h1B02EFFC7072);
    check("enc_first_round", 64'(sk_if.round), 64'd0);
    wait_done("enc");
    check("done_not_busy", 64'(busy), 64'd0);
    issue(KEY0, 1'b1, KEY0);
    check("b2b_valid", 64'(sk_if.sk_valid), 64'd1);
    check("b2b_subkey", 64'(sk_if.subkey), 64'hCB3D8B0E17F5);
    check("b2b_round", 64'(sk_if.round), 64'd15);
    wait_done("dec");
    repeat (2) tick();

    // Random backpressure.
    ready_mode = 1;
    issue(KEY0, 1'b0, KEY0);
    wait_done("stall");
    tick();

    // Flipped parity bits, plus a start with another key while busy.
    issue(KEY0 ^ 64'h0101010101010101, 1'b0, KEY0);
    repeat (4) tick();
    start = 1'b1;
    key = {$urandom, $urandom};
    decrypt = 1'b1;
    tick();
    start = 1'b0;
    check("ignore_start_busy", 64'(busy), 64'd1);
    wait_done("parity");
    tick();

    // Reset after the 5th handshake.
    ready_mode = 0;
    base = hs_count;
    issue(KEY0, 1'b0, KEY0);
    for (int i = 0; i < 200; i++) begin
      if (hs_count >= base + 5) break;
      tick();
    end
    check("rst_hs_reached", 64'(hs_count >= base + 5), 64'd1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("rst_valid", 64'(sk_if.sk_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_subkey", 64'(sk_if.subkey), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    issue(KEY0, 1'b0, KEY0);
    check("rst_restart_k1", 64'(sk_if.subkey), 64'h1B02EFFC7072);
    wait_done("restart");
    tick();

    // Random keys and directions.
    for (int t = 0; t < 6; t++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      ready_mode = int'($urandom_range(0, 1));
      issue(rk, rd, rk);
      wait_done("random");
      tick();
    end

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
